rom_stream_ctrl: RTL and testbench

Sequencer that walks the 256-entry sample ROM and streams its signed 8-bit samples to downstream DSP logic over a valid/ready interface. Software-visible controls set base address, sample count and address stride; address arithmetic wraps modulo DEPTH. The block also keeps a running signed sum of every sample transferred, used as a checksum and DC estimate. It sits between the sample ROM, which has a combinational read, and the filter datapath.

---
 rtl/rom_stream_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_rom_stream_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_ctrl.sv
// rom_stream_ctrl
//
// Walks a combinational-read sample ROM and streams its signed samples to a
// downstream consumer over a valid/ready handshake. A run is described by a
// base address, a sample count and an address stride, all captured on start.
// Addresses wrap modulo 2^ADDR_WIDTH. A running signed sum of every accepted
// sample is kept as a checksum / DC estimate.
//
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   i_start           request a run (sampled only while idle)
//   i_abort           terminate the current run immediately
//   i_base_addr       first ROM address of the run
//   i_length          number of samples, 0..2^ADDR_WIDTH
//   i_stride          address increment (0 repeats one address)
//   o_rom_addr        registered ROM address
//   i_rom_data        ROM read data for o_rom_addr
//   o_m_data          output sample
//   o_m_valid         o_m_data is valid
//   i_m_ready         downstream accepts
//   o_m_last          final sample of the run, qualified by o_m_valid
//   o_busy            a run is in progress (streaming or completing)
//   o_done            one-cycle pulse on normal completion
//   o_sum             signed sum of samples accepted in the current/last run
module rom_stream_ctrl #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int SUM_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_length,
    input  logic [ADDR_WIDTH-1:0] i_stride,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [WIDTH-1:0]      i_rom_data,
    output logic [WIDTH-1:0]      o_m_data,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic                  o_m_last,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [SUM_WIDTH-1:0]  o_sum
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] REM_ONE = (ADDR_WIDTH+1)'(1);

    state_t                r_state;
    state_t                w_next_state;

    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic [WIDTH-1:0]      r_m_data;
    logic                  r_m_valid;
    logic                  r_m_last;
    logic [SUM_WIDTH-1:0]  r_sum;

    logic                  w_handshake;
    logic                  w_load;
    logic [SUM_WIDTH-1:0]  w_sample_ext;

    assign w_handshake  = r_m_valid && i_m_ready;
    // The output register is refilled when it is empty or being drained this
    // cycle; abort wins so a discarded run never loads another sample.
    assign w_load       = (r_state == STREAM) && !i_abort &&
                          (!r_m_valid || i_m_ready) && (r_remaining != '0);
    assign w_sample_ext = {{(SUM_WIDTH-WIDTH){r_m_data[WIDTH-1]}}, r_m_data};

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves the output
        // unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next_state = (i_length == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (i_abort) begin
                    w_next_state = IDLE;
                end else if (w_handshake && r_m_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Output decode from state.
    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            STREAM: o_busy = 1'b1;
            DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
                o_done = 1'b0;
            end
        endcase
    end

    // Address sequencing, output sample register and checksum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rom_addr  <= '0;
            r_stride    <= '0;
            r_remaining <= '0;
            r_m_data    <= '0;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_sum       <= '0;
        end else begin
            // A handshake always counts, including one that coincides with
            // an abort.
            if (w_handshake) begin
                r_sum <= r_sum + w_sample_ext;
            end

            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_rom_addr  <= i_base_addr;
                        r_stride    <= i_stride;
                        r_remaining <= i_length;
                        r_sum       <= '0;
                    end
                end
                STREAM: begin
                    if (i_abort) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                    end else if (w_load) begin
                        r_m_data    <= i_rom_data;
                        r_m_valid   <= 1'b1;
                        r_m_last    <= (r_remaining == REM_ONE);
                        r_rom_addr  <= r_rom_addr + r_stride;
                        r_remaining <= r_remaining - REM_ONE;
                    end else if (w_handshake) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                    end
                end
                default: begin
                    r_m_valid <= 1'b0;
                    r_m_last  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rom_addr = r_rom_addr;
    assign o_m_data   = r_m_data;
    assign o_m_valid  = r_m_valid;
    assign o_m_last   = r_m_last;
    assign o_sum      = r_sum;

endmodule

// File: tb/tb_rom_stream_ctrl.sv
// Testbench for rom_stream_ctrl. Holds the sample ROM, a queue-based model of
// the samples a run must deliver, and a per-cycle compare process.
module tb_rom_stream_ctrl;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic        i_abort;
    logic [7:0]  i_base_addr;
    logic [8:0]  i_length;
    logic [7:0]  i_stride;
    logic [7:0]  o_rom_addr;
    logic [7:0]  i_rom_data;
    logic [7:0]  o_m_data;
    logic        o_m_valid;
    logic        i_m_ready;
    logic        o_m_last;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_sum;

    logic [7:0]  rom [256];

    rom_stream_ctrl #(.WIDTH(8), .ADDR_WIDTH(8), .SUM_WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_base_addr (i_base_addr),
        .i_length    (i_length),
        .i_stride    (i_stride),
        .o_rom_addr  (o_rom_addr),
        .i_rom_data  (i_rom_data),
        .o_m_data    (o_m_data),
        .o_m_valid   (o_m_valid),
        .i_m_ready   (i_m_ready),
        .o_m_last    (o_m_last),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_sum       (o_sum)
    );

    assign i_rom_data = rom[o_rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    // Model state
    logic [7:0]  exp_q [$];
    logic [7:0]  got   [$];
    logic [15:0] model_sum = '0;
    int          first_valid_cyc = -1;
    int          last_hs_cyc     = -1;
    int          start_cyc       = 0;
    bit          rand_ready      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) i_m_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Per-cycle compare against the model.
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            check("sum", o_sum, model_sum);
            if (prev_stall) begin
                check("stall_valid", o_m_valid, 1);
                check("stall_data", o_m_data, prev_data);
                check("stall_last", o_m_last, prev_last);
            end
            if (o_m_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", o_m_valid, 0);
                end else begin
                    check("m_data", o_m_data, exp_q[0]);
                    check("m_last", o_m_last, exp_q.size() == 1);
                end
            end
            if (o_m_valid && i_m_ready && exp_q.size() != 0) begin
                model_sum = model_sum + {{8{exp_q[0][7]}}, exp_q[0]};
                void'(exp_q.pop_front());
                got.push_back(o_m_data);
                last_hs_cyc = cyc;
            end
            prev_stall = o_m_valid && !i_m_ready && !i_abort;
            prev_data  = o_m_data;
            prev_last  = o_m_last;
            if (i_abort) exp_q.delete();
        end
    end

    // Drive a start for one cycle and load the model with the run's samples.
    task automatic launch(input int base, input int len, input int stride);
        i_base_addr = 8'(base);
        i_length    = 9'(len);
        i_stride    = 8'(stride);
        i_start     = 1'b1;
        start_cyc   = cyc;
        tick();
        i_start = 1'b0;
        exp_q.delete();
        got.delete();
        for (int i = 0; i < len; i++) exp_q.push_back(rom[(base + i * stride) % 256]);
        model_sum       = '0;
        first_valid_cyc = -1;
        last_hs_cyc     = -1;
    endtask

    // Wait for completion and check the completion timing.
    task automatic finish_run(input string tag, input int len, input bit fixed_timing);
        int done_cyc = -1;
        for (int i = 0; i < 3000 && done_cyc < 0; i++) begin
            if (o_done) done_cyc = cyc;
            else tick();
        end
        check({tag, "_done_seen"}, done_cyc >= 0, 1);
        check({tag, "_busy_at_done"}, o_busy, 1);
        if (len == 0) begin
            check({tag, "_done_c1"}, done_cyc, start_cyc + 1);
            check({tag, "_no_valid"}, first_valid_cyc, -1);
        end else begin
            check({tag, "_done_after_last"}, done_cyc, last_hs_cyc + 1);
            if (fixed_timing) begin
                check({tag, "_first_valid"}, first_valid_cyc, start_cyc + 2);
                check({tag, "_done_cyc"}, done_cyc, start_cyc + len + 2);
            end
        end
        check({tag, "_count"}, got.size(), len);
        tick();
        check({tag, "_done_pulse"}, o_done, 0);
        check({tag, "_idle"}, o_busy, 0);
    endtask

    task automatic run_stream(input string tag, input int base, input int len,
                              input int stride, input bit rnd);
        rand_ready = rnd;
        i_m_ready  = 1'b1;
        launch(base, len, stride);
        finish_run(tag, len, !rnd);
        rand_ready = 1'b0;
        i_m_ready  = 1'b1;
    endtask

    task automatic check_seq4(input string tag, input int n,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] e [4];
        e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3;
        for (int i = 0; i < n; i++) begin
            if (i < got.size()) check($sformatf("%s_s%0d", tag, i), got[i], e[i]);
            else check($sformatf("%s_s%0d_missing", tag, i), 0, 1);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'((i * 37 + 11) ^ (i >> 3));
        rom[0]   = 8'hF6; rom[1]   = 8'h02; rom[2]   = 8'h0F; rom[3] = 8'h1A;
        rom[64]  = 8'h06; rom[128] = 8'h0A; rom[192] = 8'h03;
        rom[254] = 8'hF4; rom[255] = 8'hEF;

        rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_m_ready = 1'b1;
        i_base_addr = '0; i_length = '0; i_stride = '0;
        tick(); tick();
        check("rst_rom_addr", o_rom_addr, 0);
        check("rst_m_data", o_m_data, 0);
        check("rst_m_valid", o_m_valid, 0);
        check("rst_m_last", o_m_last, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_sum", o_sum, 0);
        rst_n = 1'b1;
        tick();

        // Basic run
        run_stream("basic", 0, 4, 1, 1'b0);
        check_seq4("basic", 4, 8'hF6, 8'h02, 8'h0F, 8'h1A);
        check("basic_sum", o_sum, 16'h0021);

        // Address wrap
        run_stream("wrap", 254, 3, 1, 1'b0);
        check_seq4("wrap", 3, 8'hF4, 8'hEF, 8'hF6, 8'h00);
        check("wrap_sum", o_sum, 16'hFFD9);

        // Strides
        run_stream("stride64", 0, 4, 64, 1'b0);
        check_seq4("stride64", 4, 8'hF6, 8'h06, 8'h0A, 8'h03);
        check("stride64_sum", o_sum, 16'h0009);
        run_stream("stride0", 3, 3, 0, 1'b0);
        check_seq4("stride0", 3, 8'h1A, 8'h1A, 8'h1A, 8'h00);
        check("stride0_sum", o_sum, 16'h004E);

        // Backpressure while 0x02 is presented (cycles c+3..c+5)
        i_m_ready = 1'b1;
        launch(0, 4, 1);
        tick();
        tick();
        i_m_ready = 1'b0;
        tick();
        tick();
        tick();
        i_m_ready = 1'b1;
        finish_run("bp", 4, 1'b0);
        check_seq4("bp", 4, 8'hF6, 8'h02, 8'h0F, 8'h1A);
        check("bp_sum", o_sum, 16'h0021);

        // Abort after two handshakes; a start while busy must be ignored
        launch(0, 8, 1);
        tick();
        i_start = 1'b1; i_base_addr = 8'd100; i_length = 9'd5;
        tick();
        i_start = 1'b0; i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("abort_valid_drop", o_m_valid, 0);
        for (int i = 0; i < 4; i++) begin
            check("abort_no_done", o_done, 0);
            tick();
        end
        check("abort_idle", o_busy, 0);
        check("abort_count", got.size(), 2);
        check("abort_sum", o_sum, 16'hFFF8);

        // Zero-length run
        run_stream("len0", 9, 0, 1, 1'b0);
        check("len0_sum", o_sum, 0);

        // Full ROM sweep
        run_stream("full", 0, 256, 1, 1'b0);

        // Randomized runs under random backpressure
        for (int r = 0; r < 8; r++) begin
            run_stream($sformatf("rand%0d", r), $urandom_range(0, 255),
                       $urandom_range(1, 40), $urandom_range(0, 255), 1'b1);
        end

        // Reset mid-run
        launch(0, 256, 1);
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        exp_q.delete();
        model_sum = '0;
        tick();
        check("mrst_rom_addr", o_rom_addr, 0);
        check("mrst_m_data", o_m_data, 0);
        check("mrst_m_valid", o_m_valid, 0);
        check("mrst_m_last", o_m_last, 0);
        check("mrst_busy", o_busy, 0);
        check("mrst_done", o_done, 0);
        check("mrst_sum", o_sum, 0);
        rst_n = 1'b1;
        tick();

        // Normal operation resumes after reset
        run_stream("post_rst", 1, 3, 1, 1'b0);
        check_seq4("post_rst", 3, 8'h02, 8'h0F, 8'h1A, 8'h00);
        check("post_rst_sum", o_sum, 16'h002B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
